// File: rtl/data_bus_buffer.sv
// Bidirectional data bus buffer between the CPU bus and the PIC internal bus.
// Tri-state steering is combinational; strobes and the write latch live in the clk domain.
module data_bus_buffer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             rd_n,
  input  logic             wr_n,
  inout  logic [WIDTH-1:0] data_outside,
  inout  logic [WIDTH-1:0] data_inside,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_strobe,
  output logic             rd_strobe,
  output logic             bus_conflict
);

  logic read_en;
  logic write_en;

  assign read_en  = ~cs_n & ~rd_n & wr_n;
  assign write_en = ~cs_n & ~wr_n & rd_n;

  assign data_outside = read_en  ? data_inside  : {WIDTH{1'bz}};
  assign data_inside  = write_en ? data_outside : {WIDTH{1'bz}};

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES:0]   prime;
  logic                   rd_prev;
  logic                   wr_prev;
  logic                   write_armed;
  logic [WIDTH-1:0]       data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync <= '1;
      wr_sync <= '1;
      cs_sync <= '1;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], rd_n};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr_n};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
    end
  end

  logic rd_s;
  logic wr_s;
  logic cs_s;
  logic primed;
  logic rd_fall;
  logic wr_fall;
  logic wr_rise;
  logic conflict;
  logic write_done;

  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];
  assign cs_s = cs_sync[SYNC_STAGES-1];

  // Edges only count once the chains and the previous-value flops hold real pin samples,
  // so a strobe held low across reset release is not mistaken for a fresh edge.
  assign primed     = prime[SYNC_STAGES];
  assign rd_fall    = primed &  rd_prev & ~rd_s;
  assign wr_fall    = primed &  wr_prev & ~wr_s;
  assign wr_rise    = primed & ~wr_prev &  wr_s;
  assign conflict   = ~rd_s & ~wr_s;
  assign write_done = wr_rise & write_armed & ~cs_s & rd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime        <= '0;
      rd_prev      <= 1'b1;
      wr_prev      <= 1'b1;
      data_q       <= '0;
      write_armed  <= 1'b0;
      wr_data      <= '0;
      wr_strobe    <= 1'b0;
      rd_strobe    <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
      rd_prev   <= rd_s;
      wr_prev   <= wr_s;
      data_q    <= data_outside;
      rd_strobe <= rd_fall & ~cs_s & wr_s;
      wr_strobe <= write_done;
      if (write_done) begin
        wr_data <= data_q;
      end
      if (conflict) begin
        bus_conflict <= 1'b1;
      end
      // A write is only completed if it began cleanly and never overlapped a read.
      if (conflict || wr_rise) begin
        write_armed <= 1'b0;
      end else if (wr_fall && !cs_s && rd_s) begin
        write_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_buffer.sv
// Randomized self-checking bench for data_bus_buffer: the bench plays both CPU and PIC
// bus drivers and predicts bus values, strobe counts, strobe latency and the write latch.
module tb_data_bus_buffer;

  localparam int WIDTH = 8;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cs_n;
  logic             rd_n;
  logic             wr_n;
  logic [WIDTH-1:0] cpu_val;
  logic [WIDTH-1:0] pic_val;
  wire  [WIDTH-1:0] data_outside;
  wire  [WIDTH-1:0] data_inside;
  logic [WIDTH-1:0] wr_data;
  logic             wr_strobe;
  logic             rd_strobe;
  logic             bus_conflict;

  // The environment drives a bus side only when the buffer is not supposed to drive it,
  // so any unwanted drive from the buffer corrupts the value read back.
  wire cpu_oe = !(!cs_n && !rd_n && wr_n);
  wire pic_oe = !(!cs_n && !wr_n && rd_n);
  assign data_outside = cpu_oe ? cpu_val : {WIDTH{1'bz}};
  assign data_inside  = pic_oe ? pic_val : {WIDTH{1'bz}};

  data_bus_buffer #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cs_n(cs_n),
    .rd_n(rd_n),
    .wr_n(wr_n),
    .data_outside(data_outside),
    .data_inside(data_inside),
    .wr_data(wr_data),
    .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tick = 0;
  int rd_cnt, wr_cnt, rd_at, wr_at;
  logic [WIDTH-1:0] exp_wr_data;
  logic             exp_conflict;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rd_strobe) begin
        rd_cnt++;
        rd_at = tick;
      end
      if (wr_strobe) begin
        wr_cnt++;
        wr_at = tick;
      end
      tick++;
    end
  endtask

  task automatic checkBuses(input string tag);
    logic [WIDTH-1:0] exp_out;
    logic [WIDTH-1:0] exp_in;
    #1;
    exp_out = (!cs_n && !rd_n && wr_n) ? pic_val : cpu_val;
    exp_in  = (!cs_n && !wr_n && rd_n) ? cpu_val : pic_val;
    checkOutput({tag, "_outside"}, 32'(data_outside), 32'(exp_out));
    checkOutput({tag, "_inside"}, 32'(data_inside), 32'(exp_in));
  endtask

  // kind: 0 read, 1 write, 2 read+write together, 3 write with cs high, 4 read with cs high
  task automatic applyStimulus(input int kind, input int len);
    int fall;
    int rise;
    cpu_val = WIDTH'($urandom);
    pic_val = WIDTH'($urandom);
    runCycles(2);
    if (kind >= 3) begin
      cs_n = 1'b1;
      runCycles(3);
    end
    rd_cnt = 0;
    wr_cnt = 0;
    rd_at  = -1;
    wr_at  = -1;
    fall = tick - 1;
    rd_n = !(kind == 0 || kind == 2 || kind == 4);
    wr_n = !(kind == 1 || kind == 2 || kind == 3);
    checkBuses("fall");
    runCycles(len);
    checkBuses("hold");
    rise = tick - 1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    checkBuses("rise");
    runCycles(8);
    if (kind == 1) exp_wr_data = cpu_val;
    if (kind == 2) exp_conflict = 1'b1;
    checkOutput("rd_count", rd_cnt, (kind == 0) ? 1 : 0);
    checkOutput("wr_count", wr_cnt, (kind == 1) ? 1 : 0);
    if (kind == 0) checkOutput("rd_latency", rd_at - fall, LAT);
    if (kind == 1) checkOutput("wr_latency", wr_at - rise, LAT);
    checkOutput("wr_data", 32'(wr_data), 32'(exp_wr_data));
    checkOutput("bus_conflict", 32'(bus_conflict), 32'(exp_conflict));
    if (kind >= 3) begin
      cs_n = 1'b0;
      runCycles(3);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int directed[5] = '{0, 1, 3, 4, 2};
    rst_n        = 1'b0;
    cs_n         = 1'b0;
    rd_n         = 1'b1;
    wr_n         = 1'b1;
    cpu_val      = WIDTH'($urandom);
    pic_val      = WIDTH'($urandom);
    exp_wr_data  = '0;
    exp_conflict = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    rd_at  = -1;
    wr_at  = -1;

    runCycles(3);
    checkOutput("reset_wr_data", 32'(wr_data), 0);
    checkOutput("reset_wr_strobe", 32'(wr_strobe), 0);
    checkOutput("reset_rd_strobe", 32'(rd_strobe), 0);
    checkOutput("reset_conflict", 32'(bus_conflict), 0);
    checkBuses("idle");
    rst_n = 1'b1;
    runCycles(5);

    foreach (directed[i]) applyStimulus(directed[i], 10);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(4, 12)));
    end

    // Reset in the middle of a write discards it and clears the latch at once.
    cpu_val = WIDTH'($urandom);
    wr_n = 1'b0;
    runCycles(5);
    rst_n = 1'b0;
    #1;
    checkOutput("midwrite_reset_wr_data", 32'(wr_data), 0);
    checkOutput("midwrite_reset_conflict", 32'(bus_conflict), 0);
    exp_wr_data  = '0;
    exp_conflict = 1'b0;
    runCycles(3);
    rst_n = 1'b1;
    wr_cnt = 0;
    runCycles(6);
    wr_n = 1'b1;
    runCycles(8);
    checkOutput("post_reset_wr_count", wr_cnt, 0);
    checkOutput("post_reset_wr_data", 32'(wr_data), 0);

    applyStimulus(1, 6);
    applyStimulus(0, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
